// File: rtl/multiplier_booth_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_booth_seq
// Description : Sequential radix-2 Booth multiplier, one step per clock,
//               full signed 2*REG_SIZE-bit product split into HI/LO words.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_booth_seq #(
    parameter int REG_SIZE = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [REG_SIZE-1:0] multiplicand,
    input  logic [REG_SIZE-1:0] multiplier,
    output logic                busy,
    output logic                done,
    output logic [REG_SIZE-1:0] product_hi,
    output logic [REG_SIZE-1:0] product_lo
);

    localparam int CW = $clog2(REG_SIZE) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [REG_SIZE:0]   r_m;
    logic [REG_SIZE:0]   r_a;
    logic [REG_SIZE-1:0] r_q;
    logic                r_q1;

    logic [REG_SIZE:0]   w_sum;
    logic [REG_SIZE:0]   w_a_sh;
    logic [REG_SIZE-1:0] w_q_sh;
    logic                w_last;

    // Extra accumulator bit keeps A - M exact when M is the most-negative value.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_sh = {w_sum[REG_SIZE], w_sum[REG_SIZE:1]};
    assign w_q_sh = {w_sum[0], r_q[REG_SIZE-1:1]};
    assign w_last = (r_count == CW'(REG_SIZE - 1));

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_m        <= '0;
            r_a        <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= {multiplicand[REG_SIZE-1], multiplicand};
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_q1    <= 1'b0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_sh;
                    r_q     <= w_q_sh;
                    r_q1    <= r_q[0];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        product_hi <= w_a_sh[REG_SIZE-1:0];
                        product_lo <= w_q_sh;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_booth_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_booth_seq
// Description : Self-checking bench for multiplier_booth_seq against a
//               64-bit signed reference multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_booth_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multiplier_booth_seq #(.REG_SIZE(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return 64'(a * b);
    endfunction

    // Called at a negedge: request accepted on the next posedge, start dropped after it.
    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clock);
        @(negedge clock);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        chk("done_after_accept", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_done(output int n, output bit changed, output bit overlap);
        logic [63:0] held;
        held    = {product_hi, product_lo};
        n       = 0;
        changed = 1'b0;
        overlap = 1'b0;
        while (!done && n < 60) begin
            if ({product_hi, product_lo} !== held) changed = 1'b1;
            if (busy && done) overlap = 1'b1;
            @(negedge clock);
            n++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic run_check(input string tag, input logic [31:0] m, input logic [31:0] q,
                             input logic [63:0] exp);
        int n;
        bit ch;
        bit ov;
        launch(m, q);
        wait_done(n, ch, ov);
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_product"}, {product_hi, product_lo}, exp);
        chk({tag, "_stable_overlap"}, {62'd0, ch, ov}, 64'd0);
    endtask

    initial begin
        int  n;
        bit  ch;
        bit  ov;
        bit  saw_done;
        logic [31:0] m;
        logic [31:0] q;

        clear        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clock);
        // Start asserted with clear: clear must win.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("reset_state", {30'd0, busy, done, product_hi, product_lo}, 64'd0);
        clear = 1'b0;
        @(negedge clock);
        chk("idle_after_reset", {62'd0, busy, done}, 64'd0);

        run_check("m7_qm3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clock);
        chk("done_one_cycle", {62'd0, busy, done}, 64'd0);
        run_check("minneg_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_check("maxpos_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        run_check("minneg_x1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

        // Start during RUN is ignored; then back-to-back through the done cycle.
        @(negedge clock);
        launch(32'd5, 32'd6);
        repeat (9) @(negedge clock);
        start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
        @(negedge clock);
        start = 1'b0;
        wait_done(n, ch, ov);
        chk("ignore_latency", 64'(n + 10), 64'd32);
        chk("ignore_product", {product_hi, product_lo}, 64'd30);
        run_check("b2b", 32'hFFFF_FFFE, 32'd4, 64'hFFFF_FFFF_FFFF_FFF8);

        // Clear mid-run abandons the operation.
        @(negedge clock);
        launch(32'd123, 32'd456);
        repeat (11) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clear_midrun", {30'd0, busy, done, product_hi, product_lo}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        chk("no_done_after_clear", {63'd0, saw_done}, 64'd0);

        // Randomized signed pairs, chained back-to-back from the done cycle.
        for (int i = 0; i < 500; i++) begin
            m = $urandom;
            q = $urandom;
            if (i % 7 == 0) m = 32'h8000_0000;
            if (i % 11 == 0) q = 32'(int'($urandom_range(0, 8)) - 4);
            run_check("rand", m, q, ref_mul(m, q));
        end

        // Small positive operands: product_lo divided by Q recovers M.
        for (int i = 0; i < 20; i++) begin
            m = 32'($urandom_range(1, 65535));
            q = 32'($urandom_range(1, 65535));
            run_check("small", m, q, ref_mul(m, q));
            chk("div_inverse", 64'(product_lo / q), 64'(m));
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
